// File: rtl/sdram_arbiter.sv
// Round-robin arbiter for NUM_CH single-word requesters onto the SDRAM controller Avalon-MM s1 port.
// Optional burst lock is enabled by defining SDRAM_ARB_LOCK_EN.
module sdram_arbiter #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]        req_readdata,
  output logic [NUM_CH-1:0]        req_finished,
  output logic [NUM_CH-1:0]        o_grant,
`ifdef SDRAM_ARB_LOCK_EN
  input  logic [NUM_CH-1:0]        i_lock,
`endif
  output logic [ADDR_W-1:0]        new_sdram_controller_0_s1_address,
  output logic [DATA_W/8-1:0]      new_sdram_controller_0_s1_byteenable_n,
  output logic                     new_sdram_controller_0_s1_chipselect,
  output logic [DATA_W-1:0]        new_sdram_controller_0_s1_writedata,
  output logic                     new_sdram_controller_0_s1_read_n,
  output logic                     new_sdram_controller_0_s1_write_n,
  input  logic [DATA_W-1:0]        new_sdram_controller_0_s1_readdata,
  input  logic                     new_sdram_controller_0_s1_readdatavalid,
  input  logic                     new_sdram_controller_0_s1_waitrequest
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0]   finished_q, finished_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic                cs_q, cs_d;
  logic                read_n_q, read_n_d;
  logic                write_n_q, write_n_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic                op_wr_q, op_wr_d;
`ifdef SDRAM_ARB_LOCK_EN
  logic                lock_q, lock_d;
`endif

  logic [NUM_CH-1:0]   pend;
  logic                win_valid;
  logic [IdxW-1:0]     win_idx;
  logic [IdxW:0]       cand;
  logic                accept;

  assign accept = cs_q && !new_sdram_controller_0_s1_waitrequest;

  // Scan last+1 .. last (modulo NUM_CH); first pending channel wins.
  always_comb begin
    pend      = req_read | req_write;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = {1'b0, last_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NUM_CH)) cand = cand - (IdxW+1)'(NUM_CH);
      if (!win_valid && pend[cand[IdxW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
`ifdef SDRAM_ARB_LOCK_EN
    if (lock_q && pend[last_q]) win_idx = last_q;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      finished_q  <= '0;
      readdata_q  <= '0;
      address_q   <= '0;
      writedata_q <= '0;
      cs_q        <= 1'b0;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
      last_q      <= IdxW'(NUM_CH - 1);
      op_wr_q     <= 1'b0;
`ifdef SDRAM_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      finished_q  <= finished_d;
      readdata_q  <= readdata_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      cs_q        <= cs_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
      last_q      <= last_d;
      op_wr_q     <= op_wr_d;
`ifdef SDRAM_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (win_valid) state_d = StIssue;
      StIssue: begin
        if (accept) begin
          state_d = (op_wr_q || new_sdram_controller_0_s1_readdatavalid) ? StDone : StRdWait;
        end
      end
      StRdWait: if (new_sdram_controller_0_s1_readdatavalid) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Strobes are registered, so the first ISSUE cycle only raises them; accept is judged
  // once they are visible to the controller.
  always_comb begin
    grant_d     = grant_q;
    finished_d  = '0;
    readdata_d  = readdata_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    cs_d        = cs_q;
    read_n_d    = read_n_q;
    write_n_d   = write_n_q;
    last_d      = last_q;
    op_wr_d     = op_wr_q;
`ifdef SDRAM_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          grant_d     = NUM_CH'(1) << win_idx;
          address_d   = req_addr[32'(win_idx)*ADDR_W +: ADDR_W];
          writedata_d = req_writedata[32'(win_idx)*DATA_W +: DATA_W];
          op_wr_d     = req_write[win_idx];
          last_d      = win_idx;
        end
`ifdef SDRAM_ARB_LOCK_EN
        if (!pend[last_q]) lock_d = 1'b0;
`endif
      end
      StIssue: begin
        if (!cs_q) begin
          cs_d      = 1'b1;
          read_n_d  = op_wr_q;
          write_n_d = !op_wr_q;
        end else if (accept) begin
          cs_d      = 1'b0;
          read_n_d  = 1'b1;
          write_n_d = 1'b1;
          if (op_wr_q) begin
            finished_d = grant_q;
          end else if (new_sdram_controller_0_s1_readdatavalid) begin
            readdata_d = new_sdram_controller_0_s1_readdata;
            finished_d = grant_q;
          end
        end
      end
      StRdWait: begin
        if (new_sdram_controller_0_s1_readdatavalid) begin
          readdata_d = new_sdram_controller_0_s1_readdata;
          finished_d = grant_q;
        end
      end
      StDone: begin
        grant_d = '0;
`ifdef SDRAM_ARB_LOCK_EN
        lock_d  = i_lock[last_q];
`endif
      end
      default: ;
    endcase
  end

  assign req_readdata                           = readdata_q;
  assign req_finished                           = finished_q;
  assign o_grant                                = grant_q;
  assign new_sdram_controller_0_s1_address      = address_q;
  assign new_sdram_controller_0_s1_byteenable_n = '0;
  assign new_sdram_controller_0_s1_chipselect   = cs_q;
  assign new_sdram_controller_0_s1_writedata    = writedata_q;
  assign new_sdram_controller_0_s1_read_n       = read_n_q;
  assign new_sdram_controller_0_s1_write_n      = write_n_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter: reset, single write/read timing,
// round-robin order, read+write collision and two-channel alternation (or lock).
`timescale 1ns/1ps
module tb_sdram_arbiter;
  localparam int NUM_CH = 5;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        req_read, req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]        readdata;
  logic [NUM_CH-1:0]        finished, grant;
  logic [ADDR_W-1:0]        address;
  logic [DATA_W/8-1:0]      be_n;
  logic                     cs, read_n, write_n;
  logic [DATA_W-1:0]        writedata, s1_readdata;
  logic                     readdatavalid, waitrequest;
`ifdef SDRAM_ARB_LOCK_EN
  logic [NUM_CH-1:0]        lock;
`endif

  always #5 clk = ~clk;

  sdram_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk                                  (clk),
    .i_rst                                  (rst_n),
    .req_read                               (req_read),
    .req_write                              (req_write),
    .req_addr                               (req_addr),
    .req_writedata                          (req_writedata),
    .req_readdata                           (readdata),
    .req_finished                           (finished),
    .o_grant                                (grant),
`ifdef SDRAM_ARB_LOCK_EN
    .i_lock                                 (lock),
`endif
    .new_sdram_controller_0_s1_address      (address),
    .new_sdram_controller_0_s1_byteenable_n (be_n),
    .new_sdram_controller_0_s1_chipselect   (cs),
    .new_sdram_controller_0_s1_writedata    (writedata),
    .new_sdram_controller_0_s1_read_n       (read_n),
    .new_sdram_controller_0_s1_write_n      (write_n),
    .new_sdram_controller_0_s1_readdata     (s1_readdata),
    .new_sdram_controller_0_s1_readdatavalid(readdatavalid),
    .new_sdram_controller_0_s1_waitrequest  (waitrequest)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Auto-responder: zero wait states, readdatavalid the cycle after a read accept.
  bit          auto_mode = 1'b0;
  int          svc_left [NUM_CH];
  int          fin_log [$];
  int          wr_acc = 0;
  int          rd_acc = 0;
  logic        rdv_next = 1'b0;
  logic        last_rd = 1'b0;
  logic [31:0] rd_exp = '0;

  always @(negedge clk) begin
    if (rst_n && finished != '0) begin
      check_eq("fin_onehot", 64'($onehot(finished)), 64'd1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (finished[c]) begin
          fin_log.push_back(c);
          if (auto_mode && svc_left[c] > 0) begin
            svc_left[c]--;
            if (svc_left[c] == 0) begin
              req_read[c]  = 1'b0;
              req_write[c] = 1'b0;
            end
          end
        end
      end
      if (auto_mode && last_rd) check_eq("rd_data", readdata, rd_exp);
    end
    if (auto_mode) begin
      readdatavalid = rdv_next;
      s1_readdata   = rd_exp;
      rdv_next      = 1'b0;
      if (cs && !waitrequest && !read_n) begin
        rdv_next = 1'b1;
        rd_exp   = {9'h0, address} ^ 32'hA5A5_0000;
        last_rd  = 1'b1;
        rd_acc++;
      end
      if (cs && !waitrequest && !write_n) begin
        last_rd = 1'b0;
        wr_acc++;
      end
    end
  end

  task automatic wait_fins(input int n, input string tag);
    for (int k = 0; k < 300 && fin_log.size() < n; k++) @(negedge clk);
    check_eq(tag, 64'(fin_log.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int low_cnt;
  int exp_seq [$];

  initial begin
    rst_n = 1'b0;
    req_read = '0; req_write = '0; req_addr = '0; req_writedata = '0;
    s1_readdata = '0; readdatavalid = 1'b0; waitrequest = 1'b0;
    for (int c = 0; c < NUM_CH; c++) svc_left[c] = 0;
`ifdef SDRAM_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_fin", finished, 0);
    check_eq("rst_cs", cs, 0);
    check_eq("rst_strobes", {read_n, write_n}, 2'b11);
    check_eq("rst_addr", address, 0);
    check_eq("rst_be_n", be_n, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted while a read strobe is low.
    req_read[4] = 1'b1;
    req_addr[4*ADDR_W +: ADDR_W] = 23'h55;
    waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t1_read_low", read_n, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t1_read_n", read_n, 1);
    check_eq("t1_cs", cs, 0);
    check_eq("t1_grant", grant, 0);
    check_eq("t1_fin", finished, 0);
    req_read = '0;
    waitrequest = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // ch2 zero-wait write.
    req_write[2] = 1'b1;
    req_addr[2*ADDR_W +: ADDR_W] = 23'h000100;
    req_writedata[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("t2_grant", grant, 5'b00100);
    check_eq("t2_wr_idle", write_n, 1);
    @(negedge clk);
    check_eq("t2_wr_low", {cs, read_n, write_n}, 3'b110);
    check_eq("t2_addr", address, 23'h000100);
    check_eq("t2_wdata", writedata, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("t2_fin", finished, 5'b00100);
    check_eq("t2_wr_high", write_n, 1);
    req_write[2] = 1'b0;
    @(negedge clk);
    check_eq("t2_fin_pulse", finished, 0);
    check_eq("t2_grant_clr", grant, 0);

    // ch0 read with 3 wait states, readdatavalid 2 cycles after accept.
    req_read[0] = 1'b1;
    req_addr[0 +: ADDR_W] = 23'h7FFFFF;
    waitrequest = 1'b1;
    s1_readdata = 32'h12345678;
    low_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (read_n == 1'b0) low_cnt++;
      if (k == 1) check_eq("t3_addr", address, 23'h7FFFFF);
      if (k == 4) waitrequest = 1'b0;
      if (k == 6) readdatavalid = 1'b1;
      if (k == 7) begin
        check_eq("t3_fin", finished, 5'b00001);
        check_eq("t3_rdata", readdata, 32'h12345678);
        readdatavalid = 1'b0;
        req_read[0] = 1'b0;
      end
      if (k == 8) check_eq("t3_fin_pulse", finished, 0);
    end
    check_eq("t3_strobe_cycles", 64'(low_cnt), 64'd4);

    // All channels read continuously from reset: 0,1,2,3,4,0.
    do_reset();
    auto_mode = 1'b1;
    fin_log.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      svc_left[c] = (c == 0) ? 2 : 1;
      req_addr[c*ADDR_W +: ADDR_W] = 23'(32'h1000 * (c + 1) + 32'h3);
    end
    req_read = 5'b11111;
    wait_fins(6, "t4_count");
    exp_seq = '{0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 6 && i < fin_log.size(); i++) check_eq($sformatf("t4_order%0d", i),
                                                              64'(fin_log[i]), 64'(exp_seq[i]));
    repeat (4) @(negedge clk);

    // ch1 read+write together: write wins, single completion.
    fin_log.delete();
    wr_acc = 0;
    rd_acc = 0;
    svc_left[1] = 1;
    req_read[1] = 1'b1;
    req_write[1] = 1'b1;
    wait_fins(1, "t5_count");
    repeat (6) @(negedge clk);
    check_eq("t5_single", 64'(fin_log.size()), 64'd1);
    if (fin_log.size() > 0) check_eq("t5_ch", 64'(fin_log[0]), 64'd1);
    check_eq("t5_wr_acc", 64'(wr_acc), 64'd1);
    check_eq("t5_rd_acc", 64'(rd_acc), 64'd0);

    // ch3 writes held, ch0 joins once ch3 is granted.
    fin_log.delete();
`ifdef SDRAM_ARB_LOCK_EN
    lock = 5'b01000;
    svc_left[3] = 4;
    exp_seq = '{3, 3, 3, 3, 0};
`else
    svc_left[3] = 2;
    exp_seq = '{3, 0, 3, 0};
`endif
    req_write[3] = 1'b1;
    for (int k = 0; k < 50 && grant != 5'b01000; k++) @(negedge clk);
    check_eq("t6_first_grant", grant, 5'b01000);
    svc_left[0] = 2;
    req_read[0] = 1'b1;
    wait_fins(exp_seq.size(), "t6_count");
    for (int i = 0; i < exp_seq.size() && i < fin_log.size(); i++)
      check_eq($sformatf("t6_order%0d", i), 64'(fin_log[i]), 64'(exp_seq[i]));
    repeat (4) @(negedge clk);
`ifdef SDRAM_ARB_LOCK_EN
    lock = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
